dp_sync_ram_be: RTL



---
 rtl/dp_sync_ram_be.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dp_sync_ram_be.sv
// Dual-port synchronous RAM with byte-lane write enables, 1- or 2-cycle
// registered read pipeline per port, and same-address collision tracking.

// One byte lane of the array. Both ports may write in the same cycle. The
// priority port's write comes last, so it wins when both ports write the
// same address on this lane.
module dp_ram_lane #(
  parameter int ADDR_WIDTH    = 4,
  parameter int PRIORITY_PORT = 0
) (
  input  logic                       clk,
  input  logic [1:0]                 wr,
  input  logic [1:0][ADDR_WIDTH-1:0] addr,
  input  logic [1:0][7:0]            wdata,
  output logic [1:0][7:0]            rdata
);
  localparam int HI = PRIORITY_PORT;
  localparam int LO = 1 - PRIORITY_PORT;

  logic [7:0] mem [2**ADDR_WIDTH];

  // Lane writes. The later non-blocking assignment wins on an address tie.
  always_ff @(posedge clk) begin
    if (wr[LO]) mem[addr[LO]] <= wdata[LO];
    if (wr[HI]) mem[addr[HI]] <= wdata[HI];
  end

  // The array is read before the edge, so a same-edge write is not seen (read-first).
  assign rdata[0] = mem[addr[0]];
  assign rdata[1] = mem[addr[1]];
endmodule

module dp_sync_ram_be #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int READ_LATENCY  = 1,
  parameter int PRIORITY_PORT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_0,
  input  logic                    cs_1,
  input  logic                    we_0,
  input  logic                    we_1,
  input  logic                    oe_0,
  input  logic                    oe_1,
  input  logic [DATA_WIDTH/8-1:0] be_0,
  input  logic [DATA_WIDTH/8-1:0] be_1,
  input  logic [ADDR_WIDTH-1:0]   addr_0,
  input  logic [ADDR_WIDTH-1:0]   addr_1,
  input  logic [DATA_WIDTH-1:0]   data_in_0,
  input  logic [DATA_WIDTH-1:0]   data_in_1,
  output logic [DATA_WIDTH-1:0]   data_out_0,
  output logic [DATA_WIDTH-1:0]   data_out_1,
  output logic                    valid_0,
  output logic                    valid_1,
  output logic                    collision,
  output logic [7:0]              collision_count,
  input  logic                    clr_count
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("dp_sync_ram_be: DATA_WIDTH must be a positive multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dp_sync_ram_be: READ_LATENCY must be 1 or 2");
  end
  if (PRIORITY_PORT != 0 && PRIORITY_PORT != 1) begin : g_bad_priority
    $error("dp_sync_ram_be: PRIORITY_PORT must be 0 or 1");
  end

  logic [1:0]                       wr_en, rd_en;
  logic [1:0][ADDR_WIDTH-1:0]       addr;
  logic [1:0][NUM_LANES-1:0]        be;
  logic [1:0][DATA_WIDTH-1:0]       wdata, rd_word, rd_data;
  logic [1:0]                       rd_vld;
  logic [NUM_LANES-1:0][1:0][7:0]   lane_rd;
  logic                             coll_now;

  // A write takes precedence over a read; cs & we & oe issues no read.
  assign wr_en = {cs_1 & we_1, cs_0 & we_0};
  assign rd_en = {cs_1 & oe_1 & ~we_1, cs_0 & oe_0 & ~we_0};
  assign addr  = {addr_1, addr_0};
  assign be    = {be_1, be_0};
  assign wdata = {data_in_1, data_in_0};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dp_ram_lane #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .PRIORITY_PORT (PRIORITY_PORT)
    ) u_lane (
      .clk   (clk),
      .wr    ({wr_en[1] & be[1][l], wr_en[0] & be[0][l]}),
      .addr  (addr),
      .wdata ({wdata[1][8*l +: 8], wdata[0][8*l +: 8]}),
      .rdata (lane_rd[l])
    );
  end

  // Reassemble the per-lane read bytes into one word per port.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < NUM_LANES; l++)
        rd_word[p][8*l +: 8] = lane_rd[l][p];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [READ_LATENCY:1]                 vld_q;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_q;
    logic [READ_LATENCY:0]                 vld_pipe;
    logic [READ_LATENCY:0][DATA_WIDTH-1:0] dat_pipe;

    // Index 0 is the read being issued this cycle; higher indices are registered.
    assign vld_pipe = {vld_q, rd_en[p]};
    assign dat_pipe = {dat_q, rd_word[p]};

    // Read pipeline. A stage only loads when a read is in it, so the last
    // stage holds the previous result between reads. Reset drops in-flight reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_pipe[READ_LATENCY-1:0];
        for (int k = 1; k <= READ_LATENCY; k++)
          if (vld_pipe[k-1]) dat_q[k] <= dat_pipe[k-1];
      end
    end

    assign rd_vld[p]  = vld_q[READ_LATENCY];
    assign rd_data[p] = dat_q[READ_LATENCY];
  end

  assign data_out_0 = rd_data[0];
  assign data_out_1 = rd_data[1];
  assign valid_0    = rd_vld[0];
  assign valid_1    = rd_vld[1];

  // A collision is any same-address cycle where at least one port writes.
  // A write with no byte lanes enabled still counts.
  assign coll_now = cs_0 & cs_1 & (addr_0 == addr_1) & (we_0 | we_1);

  // Collision pulse and saturating counter. A clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      collision       <= 1'b0;
      collision_count <= '0;
    end else begin
      collision <= coll_now;
      if (clr_count)
        collision_count <= '0;
      else if (coll_now && collision_count != 8'hFF)
        collision_count <= collision_count + 8'd1;
    end
  end
endmodule
